// File: rtl/vx_commit_arbiter_pkg.sv
// rtl/vx_commit_arbiter_pkg.sv - shared widths and beat record for the commit arbiter
package vx_commit_arbiter_pkg;

  localparam int CA_NUM_REQS    = 4;
  localparam int CA_NUM_THREADS = 4;
  localparam int CA_XLEN        = 32;
  localparam int CA_NR_BITS     = 6;
  localparam int CA_UUID_WIDTH  = 44;
  localparam int CA_WIS_W       = 2;
  localparam int CA_PC_BITS     = 30;
  localparam int COMMIT_CNT_W   = 64;

  typedef struct packed {
    logic [CA_UUID_WIDTH-1:0]          uuid;
    logic [CA_WIS_W-1:0]               wis;
    logic [CA_NUM_THREADS-1:0]         tmask;
    logic [CA_PC_BITS-1:0]             PC;
    logic                              wb;
    logic [CA_NR_BITS-1:0]             rd;
    logic [CA_NUM_THREADS*CA_XLEN-1:0] data;
    logic                              sop;
    logic                              eop;
  } commit_beat_t;

endpackage

// File: rtl/vx_lock_rr_arbiter.sv
// rtl/vx_lock_rr_arbiter.sv - round-robin grant that stays on one unit from sop to eop
module vx_lock_rr_arbiter #(
  parameter int NUM_REQS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  input  logic [NUM_REQS-1:0] eop,
  output logic [NUM_REQS-1:0] grant,
  output logic                locked
);

  localparam int IW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] lock_id;
  logic [IW-1:0] winner;
  logic          any_grant;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    if (reset) begin
      if (locked) begin
        // A bubble from the lock holder grants nothing but keeps the lock.
        if (valid[lock_id]) begin
          grant[lock_id] = 1'b1;
          winner         = lock_id;
          any_grant      = 1'b1;
        end
      end else begin
        for (int k = 0; k < NUM_REQS; k++) begin
          idx = (int'(rr_ptr) + k) % NUM_REQS;
          if (!any_grant && valid[idx]) begin
            grant[idx] = 1'b1;
            winner     = IW'(idx);
            any_grant  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (any_grant) begin
      if (eop[winner]) begin
        locked <= 1'b0;
        rr_ptr <= (winner == IW'(NUM_REQS - 1)) ? '0 : winner + 1'b1;
      end else begin
        locked  <= 1'b1;
        lock_id <= winner;
      end
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// rtl/vx_commit_arbiter.sv - merges execute-unit results into one registered writeback port
module vx_commit_arbiter
  import vx_commit_arbiter_pkg::*;
#(
  parameter int NUM_REQS    = CA_NUM_REQS,
  parameter int NUM_THREADS = CA_NUM_THREADS,
  parameter int XLEN        = CA_XLEN,
  parameter int NR_BITS     = CA_NR_BITS,
  parameter int UUID_WIDTH  = CA_UUID_WIDTH,
  parameter int WIS_W       = CA_WIS_W,
  parameter int PC_BITS     = CA_PC_BITS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               in_valid,
  output logic [NUM_REQS-1:0]               in_ready,
  input  logic [NUM_REQS*UUID_WIDTH-1:0]    in_uuid,
  input  logic [NUM_REQS*WIS_W-1:0]         in_wis,
  input  logic [NUM_REQS*NUM_THREADS-1:0]   in_tmask,
  input  logic [NUM_REQS*PC_BITS-1:0]       in_PC,
  input  logic [NUM_REQS-1:0]               in_wb,
  input  logic [NUM_REQS*NR_BITS-1:0]       in_rd,
  input  logic [NUM_REQS*NUM_THREADS*XLEN-1:0] in_data,
  input  logic [NUM_REQS-1:0]               in_sop,
  input  logic [NUM_REQS-1:0]               in_eop,
  output logic                              writeback_valid,
  output logic [UUID_WIDTH-1:0]             writeback_uuid,
  output logic [WIS_W-1:0]                  writeback_wis,
  output logic [NUM_THREADS-1:0]            writeback_tmask,
  output logic [PC_BITS-1:0]                writeback_PC,
  output logic [NR_BITS-1:0]                writeback_rd,
  output logic [NUM_THREADS*XLEN-1:0]       writeback_data,
  output logic                              writeback_sop,
  output logic                              writeback_eop,
  output logic [COMMIT_CNT_W-1:0]           retired_count,
  output logic                              proto_error
);

  localparam int DW = NUM_THREADS * XLEN;

  logic [NUM_REQS-1:0] grant;
  logic                locked;
  logic                accepted;
  commit_beat_t        sel;

  vx_lock_rr_arbiter #(.NUM_REQS(NUM_REQS)) arb (
    .clk    (clk),
    .reset  (reset),
    .valid  (in_valid),
    .eop    (in_eop),
    .grant  (grant),
    .locked (locked)
  );

  assign in_ready = grant;
  assign accepted = |grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        sel.uuid  = in_uuid[i*UUID_WIDTH +: UUID_WIDTH];
        sel.wis   = in_wis[i*WIS_W +: WIS_W];
        sel.tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
        sel.PC    = in_PC[i*PC_BITS +: PC_BITS];
        sel.wb    = in_wb[i];
        sel.rd    = in_rd[i*NR_BITS +: NR_BITS];
        sel.data  = in_data[i*DW +: DW];
        sel.sop   = in_sop[i];
        sel.eop   = in_eop[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeback_valid <= 1'b0;
      writeback_uuid  <= '0;
      writeback_wis   <= '0;
      writeback_tmask <= '0;
      writeback_PC    <= '0;
      writeback_rd    <= '0;
      writeback_data  <= '0;
      writeback_sop   <= 1'b0;
      writeback_eop   <= 1'b0;
      retired_count   <= '0;
      proto_error     <= 1'b0;
    end else begin
      writeback_valid <= accepted & sel.wb;
      // wb=0 beats are retired without disturbing the last written fields.
      if (accepted && sel.wb) begin
        writeback_uuid  <= sel.uuid;
        writeback_wis   <= sel.wis;
        writeback_tmask <= sel.tmask;
        writeback_PC    <= sel.PC;
        writeback_rd    <= sel.rd;
        writeback_data  <= sel.data;
        writeback_sop   <= sel.sop;
        writeback_eop   <= sel.eop;
      end
      if (accepted && sel.eop && (retired_count != '1))
        retired_count <= retired_count + COMMIT_CNT_W'(1);
      if (accepted && (locked ? sel.sop : !sel.sop))
        proto_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb/tb_vx_commit_arbiter.sv - scoreboard bench for the commit arbiter
module tb_vx_commit_arbiter;
  import vx_commit_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 128;

  typedef struct {
    commit_beat_t beat;
    bit           bubble;
  } tb_beat_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N-1:0]        in_valid = '0;
  logic [N-1:0]        in_ready;
  logic [N*44-1:0]     in_uuid = '0;
  logic [N*2-1:0]      in_wis = '0;
  logic [N*4-1:0]      in_tmask = '0;
  logic [N*30-1:0]     in_PC = '0;
  logic [N-1:0]        in_wb = '0;
  logic [N*6-1:0]      in_rd = '0;
  logic [N*DW-1:0]     in_data = '0;
  logic [N-1:0]        in_sop = '0;
  logic [N-1:0]        in_eop = '0;
  logic                writeback_valid;
  logic [43:0]         writeback_uuid;
  logic [1:0]          writeback_wis;
  logic [3:0]          writeback_tmask;
  logic [29:0]         writeback_PC;
  logic [5:0]          writeback_rd;
  logic [DW-1:0]       writeback_data;
  logic                writeback_sop;
  logic                writeback_eop;
  logic [63:0]         retired_count;
  logic                proto_error;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;
  int cyc = 0;
  tb_beat_t     unit_q[N][$];
  commit_beat_t exp_q[$];

  always #5 clk = ~clk;

  vx_commit_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wis(in_wis), .in_tmask(in_tmask), .in_PC(in_PC),
    .in_wb(in_wb), .in_rd(in_rd), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .writeback_valid(writeback_valid), .writeback_uuid(writeback_uuid),
    .writeback_wis(writeback_wis), .writeback_tmask(writeback_tmask),
    .writeback_PC(writeback_PC), .writeback_rd(writeback_rd),
    .writeback_data(writeback_data), .writeback_sop(writeback_sop),
    .writeback_eop(writeback_eop), .retired_count(retired_count),
    .proto_error(proto_error)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic commit_beat_t mk(input int u, input int n, input bit wb,
                                      input bit sop, input bit eop);
    commit_beat_t b;
    b.uuid  = 44'(u * 256 + n);
    b.wis   = 2'(n);
    b.tmask = 4'(n + 1);
    b.PC    = 30'(u * 4096 + n * 4);
    b.wb    = wb;
    b.rd    = 6'(u * 8 + n + 1);
    for (int l = 0; l < 4; l++) b.data[l*32 +: 32] = 32'(u * 32'h100_0000 + n * 256 + l);
    b.sop   = sop;
    b.eop   = eop;
    return b;
  endfunction

  task automatic q_beat(input int u, input commit_beat_t b);
    tb_beat_t t;
    t.beat = b;
    t.bubble = 1'b0;
    unit_q[u].push_back(t);
  endtask

  task automatic q_bubble(input int u);
    tb_beat_t t;
    t.beat = '0;
    t.bubble = 1'b1;
    unit_q[u].push_back(t);
  endtask

  task automatic drive_unit(input int u, input commit_beat_t b);
    in_valid[u]          = 1'b1;
    in_uuid[u*44 +: 44]  = b.uuid;
    in_wis[u*2 +: 2]     = b.wis;
    in_tmask[u*4 +: 4]   = b.tmask;
    in_PC[u*30 +: 30]    = b.PC;
    in_wb[u]             = b.wb;
    in_rd[u*6 +: 6]      = b.rd;
    in_data[u*DW +: DW]  = b.data;
    in_sop[u]            = b.sop;
    in_eop[u]            = b.eop;
  endtask

  task automatic compare_out(input commit_beat_t e);
    check("wb_uuid", 128'(writeback_uuid), 128'(e.uuid));
    check("wb_rd", 128'(writeback_rd), 128'(e.rd));
    check("wb_data", writeback_data, e.data);
    check("wb_ctl", 128'({writeback_sop, writeback_eop, writeback_wis, writeback_tmask}),
          128'({e.sop, e.eop, e.wis, e.tmask}));
    check("wb_pc", 128'(writeback_PC), 128'(e.PC));
  endtask

  // Drives the per-unit queues until everything is accepted and every expected beat seen.
  task automatic run_traffic(input int budget);
    logic [N-1:0] rdy;
    bit busy;
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < budget) begin
      @(negedge clk);
      in_valid = '0;
      for (int u = 0; u < N; u++)
        if (unit_q[u].size() > 0 && !unit_q[u][0].bubble) drive_unit(u, unit_q[u][0].beat);
      #1 rdy = in_ready;
      @(posedge clk);
      for (int u = 0; u < N; u++)
        if (unit_q[u].size() > 0 && (unit_q[u][0].bubble || rdy[u])) void'(unit_q[u].pop_front());
      #1;
      if (writeback_valid) begin
        if (exp_q.size() == 0) check("unexpected_wb", 128'(writeback_valid), 128'(0));
        else compare_out(exp_q.pop_front());
      end
      cyc++;
      busy = (exp_q.size() != 0);
      for (int u = 0; u < N; u++) if (unit_q[u].size() != 0) busy = 1'b1;
    end
    if (busy) check("traffic_timeout", 128'(cyc), 128'(budget + 1));
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = '1;
    #1;
    check("rst_ready", 128'(in_ready), 128'(0));
    check("rst_valid", 128'(writeback_valid), 128'(0));
    check("rst_rd", 128'(writeback_rd), 128'(0));
    check("rst_retired", 128'(retired_count), 128'(0));
    check("rst_proto", 128'(proto_error), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    in_valid = '0;
    exp_retired = 0;
  endtask

  initial begin
    commit_beat_t b;
    // Reset state with every unit requesting.
    in_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    check("init_ready", 128'(in_ready), 128'(0));
    check("init_valid", 128'(writeback_valid), 128'(0));
    check("init_retired", 128'(retired_count), 128'(0));
    check("init_proto", 128'(proto_error), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    in_valid = '0;

    // Single beat from unit 2: same-cycle ready, next-cycle writeback.
    @(negedge clk);
    b = mk(2, 0, 1'b1, 1'b1, 1'b1);
    b.rd = 6'd5;
    b.data = 128'h0000_00A5_0000_00A5_0000_00A5_0000_00A5;
    drive_unit(2, b);
    #1 check("t1_ready", 128'(in_ready), 128'(4'b0100));
    @(posedge clk);
    #1;
    check("t1_valid", 128'(writeback_valid), 128'(1));
    check("t1_rd", 128'(writeback_rd), 128'(5));
    check("t1_data", writeback_data, b.data);
    check("t1_retired", 128'(retired_count), 128'(1));
    @(negedge clk);
    in_valid = '0;

    // Four units streaming single beats from rr_ptr=0.
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int u = 0; u < N; u++) begin
        q_beat(u, mk(u, n, 1'b1, 1'b1, 1'b1));
        exp_q.push_back(mk(u, n, 1'b1, 1'b1, 1'b1));
      end
    run_traffic(40);
    check("t2_cycles", 128'(cyc), 128'(8));
    exp_retired += 8;
    check("t2_retired", 128'(retired_count), 128'(exp_retired));

    // Unit 1 packet with a bubble; unit 3 must wait for its eop.
    q_beat(1, mk(1, 0, 1'b1, 1'b1, 1'b0));
    q_bubble(1);
    q_beat(1, mk(1, 1, 1'b1, 1'b0, 1'b0));
    q_beat(1, mk(1, 2, 1'b1, 1'b0, 1'b1));
    q_beat(3, mk(3, 4, 1'b1, 1'b1, 1'b1));
    q_beat(3, mk(3, 5, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(1, 0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(1, 1, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 2, 1'b1, 1'b0, 1'b1));
    exp_q.push_back(mk(3, 4, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(3, 5, 1'b1, 1'b1, 1'b1));
    run_traffic(40);
    exp_retired += 3;
    check("t3_retired", 128'(retired_count), 128'(exp_retired));
    check("t3_proto", 128'(proto_error), 128'(0));

    // wb=0 eop beat retires without a writeback.
    q_beat(0, mk(0, 6, 1'b0, 1'b1, 1'b1));
    run_traffic(20);
    exp_retired += 1;
    check("t4_valid", 128'(writeback_valid), 128'(0));
    check("t4_retired", 128'(retired_count), 128'(exp_retired));

    // Unit 2 locked mid-packet, then reset drops the partial packet.
    q_beat(2, mk(2, 7, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(2, 7, 1'b1, 1'b1, 1'b0));
    run_traffic(20);
    do_reset();
    q_beat(0, mk(0, 8, 1'b1, 1'b1, 1'b1));
    q_beat(2, mk(2, 9, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(0, 8, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(2, 9, 1'b1, 1'b1, 1'b1));
    run_traffic(20);
    exp_retired += 2;
    check("t5_retired", 128'(retired_count), 128'(exp_retired));
    check("t5_proto", 128'(proto_error), 128'(0));

    // Unlocked beat without sop: sticky error, beat still forwarded.
    q_beat(1, mk(1, 10, 1'b1, 1'b0, 1'b1));
    exp_q.push_back(mk(1, 10, 1'b1, 1'b0, 1'b1));
    run_traffic(20);
    check("t6_proto_set", 128'(proto_error), 128'(1));
    q_beat(3, mk(3, 11, 1'b1, 1'b1, 1'b1));
    exp_q.push_back(mk(3, 11, 1'b1, 1'b1, 1'b1));
    run_traffic(20);
    check("t6_proto_sticky", 128'(proto_error), 128'(1));
    do_reset();

    check("exp_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
